// File: rtl/ramb16_s4_port_ctrl.sv
// ============================================================================
// ramb16_s4_port_ctrl : request/response controller for one RAMB16 S4 port
//                       with a 2-entry read buffer and a whole-array fill.
// Revision 1.0
// ============================================================================
`default_nettype none

module ramb16_s4_port_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_val,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic                  ram_ssr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   fill_cnt;
  logic [DATA_WIDTH-1:0]   fill_pat;
  logic                    fill_done_r;
  logic                    inflight;
  logic [1:0]              count;
  logic [DATA_WIDTH-1:0]   buf_mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;

  logic                    accept;
  logic                    fill_issue;
  logic                    fill_last;
  logic                    pop;
  logic                    push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fill_issue = 1'b0;
    fill_last  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        fill_issue = 1'b1;
        if (fill_cnt == {ADDR_WIDTH{1'b1}}) begin
          fill_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The pop credit lets a new read in whenever the head leaves this cycle,
  // so occupancy (buffered + in flight) never exceeds two.
  always_comb begin
    rsp_valid = (count != 2'd0);
    pop       = rsp_valid & rsp_ready;
    push      = inflight;
    req_ready = (state == IDLE) & ~rst &
                ((({1'b0, count} + {2'b00, inflight}) < 3'd2) | pop);
    accept    = req_valid & req_ready;
    ram_en    = rst | accept | fill_issue;
    ram_we    = ~rst & ((accept & req_we) | fill_issue);
    ram_ssr   = rst;
    ram_addr  = fill_issue ? fill_cnt : req_addr;
    ram_di    = fill_issue ? fill_pat : req_data;
  end

  assign rsp_data  = buf_mem[rd_ptr];
  assign fill_busy = (state == FILL);
  assign fill_done = fill_done_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt    <= '0;
      fill_pat    <= '0;
      fill_done_r <= 1'b0;
      inflight    <= 1'b0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_mem[0]  <= '0;
      buf_mem[1]  <= '0;
    end else begin
      fill_done_r <= fill_last;
      if ((state == IDLE) && fill_start) begin
        fill_cnt <= '0;
        fill_pat <= fill_val;
      end else if (fill_issue) begin
        fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
      end

      // RAM_DO is only meaningful the cycle after a read; write cycles never push.
      inflight <= accept & ~req_we;
      if (push) begin
        buf_mem[wr_ptr] <= ram_do;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire
